// File: rtl/sort_pkg.sv
// Shared types and helpers for the in-place sort engine: controller states,
// sort-direction encoding and the swap counter width.
package sort_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_CMP,
    S_WRI,
    S_WRJ,
    S_NEXTJ,
    S_DONE
  } state_t;

  localparam logic ASC  = 1'b0;
  localparam logic DESC = 1'b1;

  // Enough bits to count every pairwise swap of K entries, K*(K-1)/2 at most.
  function automatic int swap_cnt_w(input int k);
    return $clog2(k * (k - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/sort_datapath.sv
// Register file, A/B operand registers, i/j index counters, comparator and
// swap counter; every register moves only under an enable from the controller.
module sort_datapath
  import sort_pkg::*;
#(
  parameter int K          = 8,
  parameter int W          = 8,
  parameter int SIGNED_CMP = 0,
  parameter int AW         = $clog2(K),
  parameter int CW         = swap_cnt_w(K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          ld_mode_i,
  input  logic          mode_i,
  input  logic          li_i,
  input  logic          ei_i,
  input  logic          lj_i,
  input  logic          ej_i,
  input  logic          ea_i,
  input  logic          eb_i,
  input  logic          csel_i,
  input  logic          we_i,
  input  logic          cnt_clr_i,
  input  logic          cnt_inc_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] swap_cnt_o,
  output logic          swap_o,
  output logic          zi_o,
  output logic          zj_o
);

  logic [W-1:0]  mem_q [K];
  logic [W-1:0]  a_q, b_q, rd_q;
  logic [AW-1:0] i_q, j_q;
  logic          mode_q;
  logic [CW-1:0] cnt_q;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          a_gt_b, a_lt_b;

  // csel=0 writes B into R[i]; csel=1 writes A into R[j] (second half of a swap).
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_addr_i;
    mem_wdata = wr_data_i;
    if (host_we_i) begin
      mem_we = 1'b1;
    end else if (we_i) begin
      mem_we    = 1'b1;
      mem_addr  = csel_i ? j_q : i_q;
      mem_wdata = csel_i ? a_q : b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int idx = 0; idx < K; idx++) mem_q[idx] <= '0;
    end else if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= ASC;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      if (li_i)      i_q <= '0;
      else if (ei_i) i_q <= i_q + AW'(1);
      if (lj_i)      j_q <= i_q + AW'(1);
      else if (ej_i) j_q <= j_q + AW'(1);
      // After a swap A follows the value now sitting in R[i].
      if (ea_i)      a_q <= csel_i ? b_q : mem_q[i_q];
      if (eb_i)      b_q <= mem_q[j_q];
      if (ld_mode_i) mode_q <= mode_i;
      if (cnt_clr_i)      cnt_q <= '0;
      else if (cnt_inc_i) cnt_q <= cnt_q + CW'(1);
      rd_q <= mem_q[rd_addr_i];
    end
  end

  if (SIGNED_CMP != 0) begin : g_signed
    assign a_gt_b = $signed(a_q) > $signed(b_q);
    assign a_lt_b = $signed(a_q) < $signed(b_q);
  end else begin : g_unsigned
    assign a_gt_b = a_q > b_q;
    assign a_lt_b = a_q < b_q;
  end

  assign swap_o     = (mode_q == DESC) ? a_lt_b : a_gt_b;
  assign zj_o       = (j_q == AW'(K - 1));
  assign zi_o       = (i_q == AW'(K - 2));
  assign rd_data_o  = rd_q;
  assign swap_cnt_o = cnt_q;

endmodule

// File: rtl/sort_engine.sv
// In-place selection-style sorter: host loads K words while idle, pulses s,
// waits for done and reads the sorted words back through the registered port.
module sort_engine
  import sort_pkg::*;
#(
  parameter int K          = 8,
  parameter int W          = 8,
  parameter int SIGNED_CMP = 0,
  localparam int AW        = $clog2(K),
  localparam int CW        = swap_cnt_w(K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic          desc,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] swap_cnt
);

  if (K < 2) begin : g_bad_k
    $error("sort_engine: K must be at least 2");
  end

  state_t state_q, state_d;
  logic   ld_mode, li, ei, lj, ej, ea, eb, csel, we, cnt_clr, cnt_inc;
  logic   swap, zi, zj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_mode = 1'b0;
    li      = 1'b0;
    ei      = 1'b0;
    lj      = 1'b0;
    ej      = 1'b0;
    ea      = 1'b0;
    eb      = 1'b0;
    csel    = 1'b0;
    we      = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_IDLE: if (s) begin
        ld_mode = 1'b1;
        li      = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_LOADA;
      end
      S_LOADA: begin
        ea      = 1'b1;
        lj      = 1'b1;
        state_d = S_LOADB;
      end
      S_LOADB: begin
        eb      = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: state_d = swap ? S_WRI : S_NEXTJ;
      S_WRI: begin
        we      = 1'b1;
        state_d = S_WRJ;
      end
      S_WRJ: begin
        we      = 1'b1;
        csel    = 1'b1;
        ea      = 1'b1;
        cnt_inc = 1'b1;
        state_d = S_NEXTJ;
      end
      S_NEXTJ: begin
        if (!zj) begin
          ej      = 1'b1;
          state_d = S_LOADB;
        end else if (!zi) begin
          ei      = 1'b1;
          state_d = S_LOADA;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (!s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);

  sort_datapath #(
    .K          (K),
    .W          (W),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_we_i  (wr_en && (state_q == S_IDLE)),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_addr_i  (rd_addr),
    .ld_mode_i  (ld_mode),
    .mode_i     (desc),
    .li_i       (li),
    .ei_i       (ei),
    .lj_i       (lj),
    .ej_i       (ej),
    .ea_i       (ea),
    .eb_i       (eb),
    .csel_i     (csel),
    .we_i       (we),
    .cnt_clr_i  (cnt_clr),
    .cnt_inc_i  (cnt_inc),
    .rd_data_o  (rd_data),
    .swap_cnt_o (swap_cnt),
    .swap_o     (swap),
    .zi_o       (zi),
    .zj_o       (zj)
  );

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: three instances (K=4 unsigned, K=4 signed, K=2) share
// stimulus; sel picks which one is started, written and observed.
module tb_sort_engine;

  logic       clk = 1'b0;
  logic       rst_n, s, desc, wr_en;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  int         sel;

  logic [7:0] rd0, rd1, rd2;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic [2:0] sc0, sc1;
  logic [0:0] sc2;

  logic [7:0] rd_data;
  logic       busy, done;
  logic [2:0] swap_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl [4];
  int         mdl_n;

  always #5 clk = ~clk;

  sort_engine #(.K(4), .W(8), .SIGNED_CMP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .s(s && (sel == 0)), .desc(desc),
    .wr_en(wr_en && (sel == 0)), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .done(done0), .swap_cnt(sc0)
  );

  sort_engine #(.K(4), .W(8), .SIGNED_CMP(1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .s(s && (sel == 1)), .desc(desc),
    .wr_en(wr_en && (sel == 1)), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .done(done1), .swap_cnt(sc1)
  );

  sort_engine #(.K(2), .W(8), .SIGNED_CMP(0)) u_k2 (
    .clk(clk), .rst_n(rst_n), .s(s && (sel == 2)), .desc(desc),
    .wr_en(wr_en && (sel == 2)), .wr_addr(wr_addr[0]), .wr_data(wr_data),
    .rd_addr(rd_addr[0]), .rd_data(rd2), .busy(busy2), .done(done2), .swap_cnt(sc2)
  );

  always_comb begin
    case (sel)
      1: begin rd_data = rd1; busy = busy1; done = done1; swap_cnt = sc1; end
      2: begin rd_data = rd2; busy = busy2; done = done2; swap_cnt = {2'b00, sc2}; end
      default: begin rd_data = rd0; busy = busy0; done = done0; swap_cnt = sc0; end
    endcase
  end

  // Reference: exchange sort on plain integers, R[i] against every later R[j].
  function automatic int val(input logic [7:0] x, input bit sgn);
    return sgn ? int'($signed(x)) : int'({24'b0, x});
  endfunction

  task automatic model_sort(input int k, input bit sgn, input bit dsc);
    logic [7:0] t;
    mdl_n = 0;
    for (int i = 0; i < k - 1; i++) begin
      for (int j = i + 1; j < k; j++) begin
        if (dsc ? (val(mdl[i], sgn) < val(mdl[j], sgn))
                : (val(mdl[i], sgn) > val(mdl[j], sgn))) begin
          t = mdl[i]; mdl[i] = mdl[j]; mdl[j] = t;
          mdl_n++;
        end
      end
    end
  endtask

  task automatic write_word(input int addr, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_word(input int addr, output logic [7:0] d);
    @(negedge clk);
    rd_addr = 2'(addr);
    @(negedge clk);
    d = rd_data;
  endtask

  // Starts a sort, scrambles s/desc/wr_en while busy, measures edges to done.
  task automatic run_sort(input bit dsc, input bit hold, output int lat, output int bcyc);
    bit ok;
    @(negedge clk);
    s = 1'b1; desc = dsc;
    @(posedge clk);
    lat = 0; bcyc = 0; ok = 1'b0;
    while (!ok && lat < 500) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (!hold) s = 1'($urandom_range(0, 1));
      desc    = 1'($urandom_range(0, 1));
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom_range(0, 255));
      @(posedge clk);
      lat++;
      #1 ok = done;
    end
    wr_en = 1'b0; desc = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d edges", lat);
    end
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL hold_done: done=%b busy=%b expected done=1 busy=0", done, busy);
        end
      end
    end
    @(negedge clk);
    s = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_return: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic sort_and_check(input int k, input bit sgn, input logic [7:0] din [4],
                                input bit dsc, input bit hold,
                                output int lat, output logic [7:0] rb [4]);
    int bcyc, exp_l;
    for (int a = 0; a < k; a++) write_word(a, din[a]);
    for (int a = 0; a < 4; a++) mdl[a] = din[a];
    model_sort(k, sgn, dsc);
    exp_l = (k - 1) + 3 * k * (k - 1) / 2 + 2 * mdl_n;
    run_sort(dsc, hold, lat, bcyc);
    checks++;
    if (lat != exp_l) begin
      errors++;
      $display("FAIL latency sel=%0d: got %0d expected %0d", sel, lat, exp_l);
    end
    checks++;
    if (bcyc != exp_l) begin
      errors++;
      $display("FAIL busy_cycles sel=%0d: got %0d expected %0d", sel, bcyc, exp_l);
    end
    checks++;
    if (swap_cnt !== 3'(mdl_n)) begin
      errors++;
      $display("FAIL swap_cnt sel=%0d: got %0d expected %0d", sel, swap_cnt, mdl_n);
    end
    for (int a = 0; a < 4; a++) rb[a] = 8'h00;
    for (int a = 0; a < k; a++) begin
      read_word(a, rb[a]);
      checks++;
      if (rb[a] !== mdl[a]) begin
        errors++;
        $display("FAIL readback sel=%0d addr=%0d: got %h expected %h", sel, a, rb[a], mdl[a]);
      end
    end
  endtask

  task automatic check_literal(input string tag, input logic [7:0] rb [4],
                               input logic [7:0] e [4], input int k);
    for (int a = 0; a < k; a++) begin
      checks++;
      if (rb[a] !== e[a]) begin
        errors++;
        $display("FAIL %s addr=%0d: got %h expected %h", tag, a, rb[a], e[a]);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; s = 1'b0; desc = 1'b0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_data = 8'd0; rd_addr = 2'd0; sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || swap_cnt !== 3'd0 || rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs sel=%0d: busy=%b done=%b swap_cnt=%0d rd=%h expected 0",
                 k, busy, done, swap_cnt, rd_data);
      end
    end
    sel = 0;
    for (int a = 0; a < 4; a++) begin
      read_word(a, d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_mem addr=%0d: got %h expected 00", a, d);
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] din [4];
    logic [7:0] e [4];
    logic [7:0] rb [4];
    int lat;
    sel = 0;
    din = '{8'd1, 8'd2, 8'd3, 8'd4};
    sort_and_check(4, 1'b0, din, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat != 21 || swap_cnt !== 3'd0) begin
      errors++;
      $display("FAIL sorted_asc: lat=%0d swap_cnt=%0d expected 21 0", lat, swap_cnt);
    end
    check_literal("sorted_asc", rb, din, 4);
    din = '{8'd4, 8'd3, 8'd2, 8'd1};
    e   = '{8'd1, 8'd2, 8'd3, 8'd4};
    sort_and_check(4, 1'b0, din, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat != 33 || swap_cnt !== 3'd6) begin
      errors++;
      $display("FAIL reverse_asc: lat=%0d swap_cnt=%0d expected 33 6", lat, swap_cnt);
    end
    check_literal("reverse_asc", rb, e, 4);
    din = '{8'd1, 8'd2, 8'd3, 8'd4};
    e   = '{8'd4, 8'd3, 8'd2, 8'd1};
    sort_and_check(4, 1'b0, din, 1'b1, 1'b0, lat, rb);
    checks++;
    if (swap_cnt !== 3'd6) begin
      errors++;
      $display("FAIL desc_swaps: got %0d expected 6", swap_cnt);
    end
    check_literal("desc_order", rb, e, 4);
    din = '{8'd5, 8'd5, 8'd5, 8'd5};
    sort_and_check(4, 1'b0, din, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat != 21 || swap_cnt !== 3'd0) begin
      errors++;
      $display("FAIL equal_words: lat=%0d swap_cnt=%0d expected 21 0", lat, swap_cnt);
    end
  endtask

  task automatic test_signed();
    logic [7:0] din [4];
    logic [7:0] e [4];
    logic [7:0] rb [4];
    int lat;
    din = '{8'h7F, 8'h80, 8'h00, 8'hFF};
    sel = 1;
    e = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    sort_and_check(4, 1'b1, din, 1'b0, 1'b0, lat, rb);
    check_literal("signed_order", rb, e, 4);
    sel = 0;
    e = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    sort_and_check(4, 1'b0, din, 1'b0, 1'b0, lat, rb);
    check_literal("unsigned_order", rb, e, 4);
  endtask

  task automatic test_hold_done();
    logic [7:0] din [4];
    logic [7:0] rb [4];
    int lat;
    sel = 0;
    din = '{8'd40, 8'd10, 8'd30, 8'd20};
    sort_and_check(4, 1'b0, din, 1'b0, 1'b1, lat, rb);
  endtask

  task automatic test_read_during_write();
    logic [7:0] old;
    sel = 0;
    read_word(1, old);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = ~old; rd_addr = 2'd1;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (rd_data !== old) begin
      errors++;
      $display("FAIL rw_same_old: got %h expected %h", rd_data, old);
    end
    @(negedge clk);
    checks++;
    if (rd_data !== ~old) begin
      errors++;
      $display("FAIL rw_same_new: got %h expected %h", rd_data, ~old);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    sel = 0;
    for (int a = 0; a < 4; a++) write_word(a, 8'(4 - a));
    @(negedge clk);
    rd_addr = 2'd0; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || swap_cnt !== 3'd0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b swap_cnt=%0d rd=%h expected 0",
               busy, done, swap_cnt, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      read_word(a, d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL async_reset_mem addr=%0d: got %h expected 00", a, d);
      end
    end
  endtask

  task automatic test_k2();
    logic [7:0] din [4];
    logic [7:0] e [4];
    logic [7:0] rb [4];
    int lat;
    sel = 2;
    din = '{8'd9, 8'd3, 8'd0, 8'd0};
    e   = '{8'd3, 8'd9, 8'd0, 8'd0};
    sort_and_check(2, 1'b0, din, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat != 6 || swap_cnt !== 3'd1) begin
      errors++;
      $display("FAIL k2: lat=%0d swap_cnt=%0d expected 6 1", lat, swap_cnt);
    end
    check_literal("k2_order", rb, e, 2);
  endtask

  task automatic test_random();
    logic [7:0] din [4];
    logic [7:0] rb [4];
    int lat;
    for (int it = 0; it < 15; it++) begin
      sel = it % 3;
      for (int a = 0; a < 4; a++) din[a] = 8'($urandom_range(0, 255));
      if (it % 5 == 4) din[1] = din[0];
      sort_and_check((sel == 2) ? 2 : 4, sel == 1, din, 1'($urandom_range(0, 1)),
                     1'b0, lat, rb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signed();
    test_hold_done();
    test_read_during_write();
    test_async_reset();
    test_k2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Parametrised in-place sorter. It combines a generalised controller FSM, a K-entry register file, A/B operand registers and i/j index counters in one block.
- Runs selection-style compare/swap over K words of width W.
- Supports runtime ascending/descending mode, an optional signed compare, and reports a swap count.
- Host loads data through a write port while idle, pulses start, waits for done, then reads the sorted data back.

Parameters:
- K, 8, number of entries; K >= 2, elaboration error otherwise.
- W, 8, data word width.
- SIGNED_CMP, 0, 1 = compare words as two's complement, 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- s  in  1  start request, level-sensitive.
- desc  in  1  mode: 0 ascending, 1 descending; sampled only on the accepting edge.
- wr_en  in  1  load strobe; honoured only in S_IDLE.
- wr_addr  in  $clog2(K)  load address.
- wr_data  in  W  load data.
- rd_addr  in  $clog2(K)  read address.
- rd_data  out  W  registered read data.
- busy  out  1  high in any working state.
- done  out  1  high in S_DONE.
- swap_cnt  out  CW  swaps performed in the last or current sort; CW = $clog2(K*(K-1)/2+1).

Behaviour:
- Reset (async, rst_n=0): state S_IDLE; i=0, j=0, A=0, B=0, mode=0; all K entries 0; rd_data=0, busy=0, done=0, swap_cnt=0.
- Read port: rd_data <= R[rd_addr] every cycle, in every state, with 1-cycle latency. While busy it returns in-progress contents. A read and write to the same address on the same edge returns the old value.
- Write port: in S_IDLE with wr_en=1, R[wr_addr] <= wr_data. wr_en is ignored in all other states.
- S_IDLE: if s=1, latch desc into mode, clear swap_cnt, set i=0, go to S_LOADA. Otherwise stay.
- S_LOADA: A <= R[i], j <= i+1, go to S_LOADB.
- S_LOADB: B <= R[j], go to S_CMP.
- S_CMP: swap = (mode=0) ? A>B : A<B. Equal words never swap. Compare is signed iff SIGNED_CMP=1. If swap, go to S_WRI; else go to S_NEXTJ.
- S_WRI: R[i] <= B, go to S_WRJ.
- S_WRJ: R[j] <= A, A <= B, swap_cnt++, go to S_NEXTJ.
- S_NEXTJ:
  - if j<K-1: j++, go to S_LOADB.
  - else if i<K-2: i++, go to S_LOADA.
  - else go to S_DONE.
- S_DONE: done=1. Stay while s=1; go to S_IDLE when s=0. A new sort requires s to drop and then rise again.
- busy = 1 in S_LOADA..S_NEXTJ.
- Latency: done rises L edges after the accepting edge, where L = (K-1) + 3*K*(K-1)/2 + 2*N and N = final swap_cnt.
- swap_cnt holds its value through S_DONE and S_IDLE until the next accepting edge.
- s or desc changes while busy have no effect.
- rst_n low mid-sort aborts immediately to the reset values; memory is cleared.
- K=2: exactly one comparison; i never increments.

Decomposition:
- Shared package sort_pkg holds:
  - state_t enum (S_IDLE, S_LOADA, S_LOADB, S_CMP, S_WRI, S_WRJ, S_NEXTJ, S_DONE);
  - function swap_cnt_w(K);
  - mode constants ASC=0, DESC=1.
- One sub-module, sort_datapath, holds the register file, A/B, i/j counters, comparator, and zi/zj/AgtB-style status flags.
- The FSM stays in sort_engine and drives the datapath enables (EA, EB, Li, Ei, Lj, Ej, Csel, WE).

Test Plan:
- K=4, W=8, load [1,2,3,4], s pulse, desc=0 -> done 21 edges after acceptance; swap_cnt=0; readback [1,2,3,4].
- Load [4,3,2,1], desc=0 -> readback [1,2,3,4]; swap_cnt=6; done after 33 edges; busy high for exactly 33 cycles.
- Load [1,2,3,4], desc=1 -> readback [4,3,2,1]; swap_cnt=6. Then load [5,5,5,5] -> swap_cnt=0, done after 21 edges.
- SIGNED_CMP=1, load [0x7F,0x80,0x00,0xFF], desc=0 -> readback [0x80,0xFF,0x00,0x7F]. With SIGNED_CMP=0 -> [0x00,0x7F,0x80,0xFF].
- Hold s=1 past done -> stays in S_DONE with done=1. wr_en during busy -> memory unchanged. Drop s -> S_IDLE, done=0.
- Assert rst_n=0 asynchronously at cycle 10 of a sort -> outputs immediately at reset values; memory reads back 0. K=2 with load [9,3] -> [3,9], swap_cnt=1, done after 6 edges.
